dip_switch_debouncer: RTL and testbench

//   Conditions the raw 4-bit DIP switch bus before it reaches the LED/tap fan-out and CPU input logic.
//   Per bit: 2-flop synchroniser, then a stability counter. Publishes a clean stable word.

---
 rtl/dip_switch_debouncer_pkg.sv | 13 +
 rtl/debounce_bit.sv | 60 ++++++
 rtl/dip_switch_debouncer.sv | 74 +++++++
 tb/tb_dip_switch_debouncer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dip_switch_debouncer_pkg.sv
// rtl/dip_switch_debouncer_pkg.sv - shared DIP switch bus sizing and debounce defaults
//
// Purpose: bus width, default debounce length and counter width. The DIP/LED
// top and the CPU input port use these values too, so they stay consistent.
// Ports:   none (package)
package dip_switch_debouncer_pkg;

  localparam int DIP_WIDTH            = 4;
  localparam int DIP_DEBOUNCE_DEFAULT = 16;
  // Wide enough to hold DIP_DEBOUNCE_DEFAULT-1
  localparam int DIP_CNT_W            = 5;

endpackage : dip_switch_debouncer_pkg

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - synchroniser and stability counter for one switch bit
//
// Purpose: brings one raw switch level into the clock domain through two
//          flops. It accepts a new level only after DEBOUNCE_CYCLES consecutive
//          samples that disagree with the published level.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   raw     in   asynchronous bouncing switch level
//   stable  out  debounced level (registered)
//   commit  out  high during the cycle whose edge flips 'stable'
module debounce_bit
  import dip_switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DIP_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = DIP_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic commit
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             w_differs;

  assign w_differs = r_s2 ^ r_stable;
  // The counter never exceeds LP_CNT_LAST: it is cleared on the edge where it
  // would pass it, so reaching the last value with a disagreement is the commit.
  assign commit    = w_differs && (r_cnt == LP_CNT_LAST);
  assign stable    = r_stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
      if (!w_differs) begin
        // A single agreeing sample restarts the qualification window
        r_cnt <= '0;
      end else if (commit) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule : debounce_bit

// File: rtl/dip_switch_debouncer.sv
// rtl/dip_switch_debouncer.sv - debounced DIP switch word with held change event
//
// Purpose: debounces each switch bit independently and publishes a clean word.
//          It raises a change event with the mask of bits that toggled. The
//          event is held until the consumer acknowledges it.
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   dip_raw       in   [WIDTH] asynchronous bouncing switch levels
//   dip_stable    out  [WIDTH] debounced switch word
//   change_valid  out  change event pending
//   change_mask   out  [WIDTH] bits toggled since last ack (valid with change_valid)
//   change_ack    in   consumer accepts the pending event
module dip_switch_debouncer
  import dip_switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = DIP_WIDTH,
  parameter int DEBOUNCE_CYCLES = DIP_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = DIP_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dip_raw,
  output logic [WIDTH-1:0] dip_stable,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_mask,
  input  logic             change_ack
);

  logic [WIDTH-1:0] w_tog;
  logic             r_valid;
  logic [WIDTH-1:0] r_mask;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (dip_raw[g]),
      .stable (dip_stable[g]),
      .commit (w_tog[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_mask  <= '0;
    end else if (!r_valid) begin
      // An ack with nothing pending is ignored
      if (w_tog != '0) begin
        r_valid <= 1'b1;
        r_mask  <= w_tog;
      end
    end else if (change_ack) begin
      // Toggles landing on the ack edge start a new event so none are lost
      if (w_tog == '0) begin
        r_valid <= 1'b0;
        r_mask  <= '0;
      end else begin
        r_mask  <= w_tog;
      end
    end else begin
      // Accumulate; a bit that toggled twice still reads as changed
      r_mask <= r_mask | w_tog;
    end
  end

  assign change_valid = r_valid;
  assign change_mask  = r_mask;

endmodule : dip_switch_debouncer

// File: tb/tb_dip_switch_debouncer.sv
// tb/tb_dip_switch_debouncer.sv - directed self-checking bench for dip_switch_debouncer
module tb_dip_switch_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dip_raw;
  logic [3:0] dip_stable;
  logic       change_valid;
  logic [3:0] change_mask;
  logic       change_ack;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dip_switch_debouncer #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dip_raw      (dip_raw),
    .dip_stable   (dip_stable),
    .change_valid (change_valid),
    .change_mask  (change_mask),
    .change_ack   (change_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] st, input logic v,
                           input logic [3:0] m);
    check({tag, ".stable"}, 32'(dip_stable), 32'(st));
    check({tag, ".valid"}, 32'(change_valid), 32'(v));
    check({tag, ".mask"}, 32'(change_mask), 32'(m));
  endtask

  task automatic ack_pulse();
    change_ack = 1'b1;
    step(1);
    change_ack = 1'b0;
  endtask

  int         run [4];
  logic [3:0] glitch;

  initial begin
    reset      = 1'b1;
    dip_raw    = 4'hF;
    change_ack = 1'b0;

    // 1: reset state, then first commit on the 6th edge after release
    step(3);
    check_out("t1_reset", 4'h0, 1'b0, 4'h0);
    reset = 1'b0;
    step(5);
    check_out("t1_edge5", 4'h0, 1'b0, 4'h0);
    step(1);
    check_out("t1_edge6", 4'hF, 1'b1, 4'hF);
    ack_pulse();
    check_out("t1_ack", 4'hF, 1'b0, 4'h0);

    // 2: drop bit2, then raise it through five 3-cycle glitches
    dip_raw = 4'hB;
    step(6);
    check_out("t2_drop", 4'hB, 1'b1, 4'h4);
    ack_pulse();
    for (int k = 0; k < 5; k++) begin
      dip_raw = 4'hF;
      step(3);
      dip_raw = 4'hB;
      step(1);
      check("t2_glitch_stable", 32'(dip_stable), 'hB);
    end
    step(5);
    check_out("t2_quiet", 4'hB, 1'b0, 4'h0);
    dip_raw = 4'hF;
    step(5);
    check_out("t2_steady5", 4'hB, 1'b0, 4'h0);
    step(1);
    check_out("t2_steady6", 4'hF, 1'b1, 4'h4);
    ack_pulse();

    // 3: bits 0 and 3 together, then bit1 accumulates without ack
    dip_raw = 4'h6;
    step(6);
    check_out("t3_b03", 4'h6, 1'b1, 4'h9);
    dip_raw = 4'h4;
    step(5);
    check_out("t3_hold", 4'h6, 1'b1, 4'h9);
    step(1);
    check_out("t3_b1", 4'h4, 1'b1, 4'hB);
    ack_pulse();
    check_out("t3_ack", 4'h4, 1'b0, 4'h0);

    // 4: ack on the same edge bit1 commits replaces the mask
    dip_raw = 4'hD;
    step(6);
    check_out("t4_b03", 4'hD, 1'b1, 4'h9);
    dip_raw = 4'hF;
    step(5);
    change_ack = 1'b1;
    step(1);
    check_out("t4_ack_tog", 4'hF, 1'b1, 4'h2);
    step(1);
    change_ack = 1'b0;
    check_out("t4_ack_clr", 4'hF, 1'b0, 4'h0);

    // 5: reset while bit0 is mid-count (cnt=2)
    dip_raw = 4'hE;
    step(4);
    reset = 1'b1;
    step(1);
    check_out("t5_reset", 4'h0, 1'b0, 4'h0);
    reset = 1'b0;
    step(5);
    check_out("t5_edge5", 4'h0, 1'b0, 4'h0);
    step(1);
    check_out("t5_edge6", 4'hE, 1'b1, 4'hE);
    ack_pulse();

    // 6: ack with nothing pending, then random short bounce
    ack_pulse();
    check_out("t6_idle_ack", 4'hE, 1'b0, 4'h0);
    glitch = 4'h0;
    for (int b = 0; b < 4; b++) run[b] = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (glitch[b]) begin
          if (run[b] >= 3 || $urandom_range(0, 1) == 0) begin
            glitch[b] = 1'b0;
            run[b]    = 0;
          end else begin
            run[b]++;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          glitch[b] = 1'b1;
          run[b]    = 1;
        end
      end
      dip_raw = 4'hE ^ glitch;
      step(1);
      check("t6_bounce_stable", 32'(dip_stable), 'hE);
    end
    dip_raw = 4'hE;
    step(6);
    check_out("t6_end", 4'hE, 1'b0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dip_switch_debouncer
